// File: rtl/sccb_slave_if.sv
// Local-side bundle of the SCCB responder: master clock input, host preload port
// and status/strobe outputs. sda is bidirectional and stays a plain inout pin on
// the slave so the pad-level tristate resolves outside the interface.
interface sccb_slave_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  scl;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  wr_strobe;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_strobe;
  logic                  busy;
  logic                  direction;

  modport slave (
    input  scl, host_we, host_addr, host_wdata,
    output wr_strobe, wr_addr, wr_data, rd_strobe, busy, direction
  );

  modport master (
    output scl, host_we, host_addr, host_wdata,
    input  wr_strobe, wr_addr, wr_data, rd_strobe, busy, direction
  );
endinterface

// File: rtl/sccb_slave.sv
// SCCB responder (camera-side model): oversamples scl/sda, decodes START/STOP,
// matches the device ID, handles 3-phase writes and 2-phase reads against a
// local register file that the host side can also preload.
module sccb_slave #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [6:0]  DEVICE_ADDRESS = 7'h42
) (
  input  logic        clk,
  input  logic        rstn,
  inout  wire         sda,
  sccb_slave_if.slave bus
);

  localparam int unsigned     Depth   = 2 ** ADDR_WIDTH;
  localparam int unsigned     CntW    = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StDevAck, StRegAddr, StRegAck,
    StWrData, StWrAck, StRdData, StRdAck, StWaitStop
  } state_e;

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;

  state_e                state_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  rw_q;
  logic                  ack_on_q;
  logic [ADDR_WIDTH-1:0] reg_ptr_q;
  logic                  sda_out_q;
  logic                  dir_q;
  logic                  busy_q;
  logic                  wr_strobe_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  rd_strobe_q;
  logic [DATA_WIDTH-1:0] regfile_q [Depth];

  // Two-flop synchronisers plus one delay flop for edge detection; idle bus is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d_q  <= 1'b1;
    end else begin
      scl_s1_q <= bus.scl;
      scl_s2_q <= scl_s1_q;
      scl_d_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_d_q  <= sda_s2_q;
    end
  end

  logic                  scl_rise, scl_fall, start_det, stop_det, last_bit, commit;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic [DATA_WIDTH-1:0] rd_word;

  assign scl_rise  = scl_s2_q & ~scl_d_q;
  assign scl_fall  = ~scl_s2_q & scl_d_q;
  assign start_det = scl_s2_q & sda_d_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_d_q & sda_s2_q;
  assign last_bit  = (bit_cnt_q == LastBit);
  assign rx_byte   = {shift_q[DATA_WIDTH-2:0], sda_s2_q};
  assign rd_word   = regfile_q[reg_ptr_q];
  assign commit    = (state_q == StWrData) & scl_rise & last_bit & ~start_det & ~stop_det;

  // Register file: an SCCB commit overrides a host preload to the same address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < Depth; i++) regfile_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (commit && reg_ptr_q == ADDR_WIDTH'(i)) begin
          regfile_q[i] <= rx_byte;
        end else if (bus.host_we && bus.host_addr == ADDR_WIDTH'(i)) begin
          regfile_q[i] <= bus.host_wdata;
        end
      end
    end
  end

  // Protocol FSM; START/STOP take priority over every state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      reg_ptr_q   <= '0;
      sda_out_q   <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      if (start_det) begin
        state_q   <= StDevAddr;
        bit_cnt_q <= '0;
        ack_on_q  <= 1'b0;
        dir_q     <= 1'b0;
        sda_out_q <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_det) begin
        state_q   <= StIdle;
        ack_on_q  <= 1'b0;
        dir_q     <= 1'b0;
        sda_out_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StDevAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              if (last_bit) begin
                bit_cnt_q <= '0;
                if (rx_byte[7:1] == DEVICE_ADDRESS) begin
                  rw_q    <= rx_byte[0];
                  state_q <= StDevAck;
                end else begin
                  state_q <= StWaitStop;
                end
              end
            end
          end
          StRegAddr: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              if (last_bit) begin
                bit_cnt_q <= '0;
                reg_ptr_q <= rx_byte[ADDR_WIDTH-1:0];
                state_q   <= StRegAck;
              end
            end
          end
          StWrData: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              if (last_bit) begin
                bit_cnt_q   <= '0;
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= reg_ptr_q;
                wr_data_q   <= rx_byte;
                state_q     <= StWrAck;
              end
            end
          end
          // First fall ends bit 8 and starts the ACK low; second fall ends the ACK clock.
          StDevAck, StRegAck, StWrAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                ack_on_q  <= 1'b1;
                dir_q     <= 1'b1;
                sda_out_q <= 1'b0;
              end else begin
                ack_on_q  <= 1'b0;
                dir_q     <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == StRegAck) begin
                  state_q <= StWrData;
                end else if (state_q == StWrAck) begin
                  state_q <= StWaitStop;
                end else if (!rw_q) begin
                  state_q <= StRegAddr;
                end else begin
                  shift_q     <= {rd_word[DATA_WIDTH-2:0], 1'b0};
                  sda_out_q   <= rd_word[DATA_WIDTH-1];
                  dir_q       <= 1'b1;
                  rd_strobe_q <= 1'b1;
                  state_q     <= StRdData;
                end
              end
            end
          end
          // MSB already on the wire; each fall presents the next bit, the 8th releases.
          StRdData: begin
            if (scl_fall) begin
              if (last_bit) begin
                dir_q     <= 1'b0;
                sda_out_q <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= StRdAck;
              end else begin
                sda_out_q <= shift_q[DATA_WIDTH-1];
                shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
          end
          // Master ack value is don't-care; leave at the end of its clock.
          StRdAck: begin
            if (scl_fall) state_q <= StWaitStop;
          end
          StIdle, StWaitStop: begin
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sda           = dir_q ? sda_out_q : 1'bz;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_strobe = rd_strobe_q;
  assign bus.busy      = busy_q;
  assign bus.direction = dir_q;

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
SCCB responder (camera-side model) for the OV7725-style 3-phase write and 2-phase read protocol. It oversamples scl/sda on a local clock, decodes START/STOP, and matches the device address. It ACKs and writes an internal register file, and drives read data back on sda. It is used as the camera stand-in for the SCCB master in simulation and FPGA loopback, and as a generic register-bank slave.

Parameters:
DATA_WIDTH, 8, register width (bits per SCCB data byte)
ADDR_WIDTH, 8, register address width; register file depth is 2**ADDR_WIDTH
DEVICE_ADDRESS, 7'h42, 7-bit slave ID; on the wire 8'h84 = write, 8'h85 = read

Ports:
clk  input  1  local clock; must be at least 8x the master's per-phase state rate
rstn  input  1  reset, asynchronous, active-low
scl  input  1  SCCB clock from master
sda  inout  1  SCCB data; driven only when direction=1, else 1'bz
host_we  input  1  local register preload strobe
host_addr  input  ADDR_WIDTH  local preload address
host_wdata  input  DATA_WIDTH  local preload data
wr_strobe  output  1  one-cycle pulse when an SCCB write commits
wr_addr  output  ADDR_WIDTH  address of committed write, held until next commit
wr_data  output  DATA_WIDTH  data of committed write, held until next commit
rd_strobe  output  1  one-cycle pulse when a read byte is loaded for transmit
busy  output  1  high from START until STOP
direction  output  1  sda output enable (debug)

Behaviour:
- Reset values: all outputs 0, sda released, state IDLE, reg_ptr 0, register file all 0.
- Input synchronisation: scl and sda each pass through 2 flops, then one delay flop for edge detection.
  - scl_rise / scl_fall are single-cycle pulses.
  - START = synced sda falls while synced scl high. STOP = synced sda rises while synced scl high.
- Sampling and driving: sda is sampled on scl_rise, MSB first. The slave changes its sda drive only on scl_fall.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START in any state: go to DEV_ADDR, clear the 3-bit bit counter, release sda, busy=1. This covers repeated start.
- STOP in any state: go to IDLE, release sda, busy=0. reg_ptr is retained across STOP.
- Note: the master's restart sequence produces STOP then START, so reg_ptr retention is mandatory.
- DEV_ADDR: shift 8 bits, then evaluate on the 8th scl_rise.
  - Match on upper 7 bits: record rw = bit0, go to DEV_ACK.
  - Mismatch: go to WAIT_STOP with sda never driven.
- ACK cycles (DEV_ACK, REG_ACK, WR_ACK):
  - On the scl_fall that ends bit 8, drive sda=0.
  - On the next scl_fall (end of the ACK clock), release sda and advance.
- Advance after DEV_ACK:
  - rw=0: go to REG_ADDR.
  - rw=1: load shifter from regfile[reg_ptr], pulse rd_strobe, drive shifter MSB on that same scl_fall, go to RD_DATA.
- REG_ADDR: after 8 bits, reg_ptr <= received byte (low ADDR_WIDTH bits), go to REG_ACK, then WR_DATA.
- WR_DATA: on the 8th scl_rise:
  - regfile[reg_ptr] <= byte.
  - wr_strobe pulses; wr_addr/wr_data update.
  - Go to WR_ACK, then WAIT_STOP. Further bytes are not ACKed.
- RD_DATA: on each scl_fall, drive the next bit. On the scl_fall ending bit 8, release sda and go to RD_ACK.
- RD_ACK: sample the master ack on scl_rise and ignore its value. On scl_fall, go to WAIT_STOP with sda released. reg_ptr is unchanged.
- WAIT_STOP: sda released; ignore scl edges; leave only on START or STOP.
- Register file write port collision: SCCB commit and host_we on the same cycle → SCCB commit wins and host_we is dropped.
  - host_we to a different address proceeds normally.
  - host_we at any other time writes immediately.
- Timing and safety:
  - Response latency from a wire edge to an sda change is 4 clk max (2 sync + 1 edge + 1 register).
  - sda is never driven while synced scl is high, except holding ACK low or a stable data bit.
- Reset mid-transaction: sda releases asynchronously with rstn low; state returns to IDLE; register file is cleared.

Test Plan:
1. Write: START, 0x84, 0x12, 0x80, STOP → slave ACKs all three bytes (sda=0 during each 9th scl high); wr_strobe pulses once with wr_addr=0x12, wr_data=0x80; busy falls after STOP.
2. Read: preload host 0x0A←0x77; send START 0x84 0x0A STOP, then START 0x85 → ACK; sda carries 0111_0111 MSB-first; rd_strobe pulses once; master ack=0 accepted; sda released before STOP; no wr_strobe.
3. Address mismatch: START, 0x60, 0x12, 0x80, STOP → direction stays 0 throughout; no strobes; regfile[0x12] unchanged.
4. STOP mid-byte: after 4 bits of the data byte in a write to 0x05, issue STOP → no wr_strobe; state IDLE; a following full write to 0x05←0x3C commits normally.
5. Collision: host_we to 0x12 with 0x11 on the exact cycle of an SCCB commit of 0x12←0xA5 → readback of 0x12 returns 0xA5.
6. Reset mid-read: assert rstn during RD_DATA while sda is driven → sda goes Z immediately; all outputs 0; the next read of 0x0A returns 0x00.
